riscv_decode_stage: RTL and testbench



---
 rtl/riscv_decode_stage_if.sv | 45 ++++
 rtl/riscv_decode_stage.sv | 216 +++++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_decode_stage_if.sv
// Fetch-to-execute bus of the RV32I decode stage: instruction/PC in, decoded bundle out.
interface riscv_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_alu_op;
  logic            out_rd_we;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_is_branch;
  logic            out_is_jal;
  logic            out_is_jalr;
  logic            out_is_lui;
  logic            out_is_auipc;
  logic            out_is_ecall;
  logic            out_is_ebreak;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3,
           out_imm, out_alu_op, out_rd_we, out_is_load, out_is_store,
           out_is_branch, out_is_jal, out_is_jalr, out_is_lui, out_is_auipc,
           out_is_ecall, out_is_ebreak, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3,
           out_imm, out_alu_op, out_rd_we, out_is_load, out_is_store,
           out_is_branch, out_is_jal, out_is_jalr, out_is_lui, out_is_auipc,
           out_is_ecall, out_is_ebreak, out_illegal
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage with saturating illegal counter.
// Define RISCV_DECODE_RV32M_EN to decode the RV32M multiply/divide group.
module riscv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  riscv_decode_stage_if.slave bus,
  output logic [CNT_W-1:0]    illegal_cnt
);
  localparam int unsigned ALU_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [ALU_W-1:0] ALU_ADD   = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'd2;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'd7;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'd8;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'd9;
  localparam logic [ALU_W-1:0] ALU_PASSB = 5'd10;
`ifdef RISCV_DECODE_RV32M_EN
  localparam logic [ALU_W-1:0] ALU_MUL   = 5'd11;
`endif

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shared funct3 -> ALU mapping for the base integer register/immediate ops
  function automatic logic [ALU_W-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0]  d_imm;
  logic [ALU_W-1:0] d_alu;
  logic d_wr, d_ill, d_rd_we;
  logic d_load, d_store, d_branch, d_jal, d_jalr, d_lui, d_auipc, d_ecall, d_ebreak;

  always_comb begin
    d_imm    = '0;
    d_alu    = ALU_ADD;
    d_wr     = 1'b0;
    d_ill    = 1'b0;
    d_load   = 1'b0;
    d_store  = 1'b0;
    d_branch = 1'b0;
    d_jal    = 1'b0;
    d_jalr   = 1'b0;
    d_lui    = 1'b0;
    d_auipc  = 1'b0;
    d_ecall  = 1'b0;
    d_ebreak = 1'b0;
    case (opcode)
      OPC_LUI:   begin d_lui = 1'b1; d_imm = XLEN'(imm_u); d_alu = ALU_PASSB; d_wr = 1'b1; end
      OPC_AUIPC: begin d_auipc = 1'b1; d_imm = XLEN'(imm_u); d_wr = 1'b1; end
      OPC_JAL:   begin d_jal = 1'b1; d_imm = XLEN'(imm_j); d_wr = 1'b1; end
      OPC_JALR: begin
        d_jalr = 1'b1; d_imm = XLEN'(imm_i); d_wr = 1'b1;
        d_ill  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_branch = 1'b1; d_imm = XLEN'(imm_b);
        d_ill    = (funct3[2:1] == 2'b01);
        case (funct3[2:1])
          2'b00:   d_alu = ALU_SUB;
          2'b10:   d_alu = ALU_SLT;
          default: d_alu = ALU_SLTU;
        endcase
      end
      OPC_LOAD: begin
        d_load = 1'b1; d_imm = XLEN'(imm_i); d_wr = 1'b1;
        d_ill  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        d_store = 1'b1; d_imm = XLEN'(imm_s);
        d_ill   = (funct3 >= 3'b011);
      end
      OPC_OPIMM: begin
        d_imm = XLEN'(imm_i); d_wr = 1'b1;
        d_alu = base_op(funct3);
        if (funct3 == 3'b001) d_ill = (funct7 != 7'h00);
        if (funct3 == 3'b101) begin
          d_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
          if (funct7 == 7'h20) d_alu = ALU_SRA;
        end
      end
      OPC_OP: begin
        d_wr = 1'b1;
        case (funct7)
          7'h00: d_alu = base_op(funct3);
          7'h20: begin
            if (funct3 == 3'b000)      d_alu = ALU_SUB;
            else if (funct3 == 3'b101) d_alu = ALU_SRA;
            else                       d_ill = 1'b1;
          end
`ifdef RISCV_DECODE_RV32M_EN
          7'h01:   d_alu = ALU_MUL + ALU_W'(funct3);
`endif
          default: d_ill = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        d_imm    = XLEN'(imm_i);
        d_ecall  = (instr == 32'h0000_0073);
        d_ebreak = (instr == 32'h0010_0073);
        d_ill    = !(d_ecall || d_ebreak);
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal encodings keep their fields but lose every side effect
    if (d_ill) begin
      d_load = 1'b0; d_store = 1'b0; d_branch = 1'b0; d_jal = 1'b0; d_jalr = 1'b0;
      d_lui  = 1'b0; d_auipc = 1'b0; d_ecall = 1'b0; d_ebreak = 1'b0;
      d_alu  = ALU_ADD;
      d_wr   = 1'b0;
    end
    d_rd_we = d_wr && (rd != 5'd0);
  end

  logic load;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_rs1       <= '0;
      bus.out_rs2       <= '0;
      bus.out_rd        <= '0;
      bus.out_funct3    <= '0;
      bus.out_imm       <= '0;
      bus.out_alu_op    <= '0;
      bus.out_rd_we     <= 1'b0;
      bus.out_is_load   <= 1'b0;
      bus.out_is_store  <= 1'b0;
      bus.out_is_branch <= 1'b0;
      bus.out_is_jal    <= 1'b0;
      bus.out_is_jalr   <= 1'b0;
      bus.out_is_lui    <= 1'b0;
      bus.out_is_auipc  <= 1'b0;
      bus.out_is_ecall  <= 1'b0;
      bus.out_is_ebreak <= 1'b0;
      bus.out_illegal   <= 1'b0;
      illegal_cnt       <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_valid     <= 1'b1;
      bus.out_pc        <= bus.in_pc;
      bus.out_rs1       <= instr[19:15];
      bus.out_rs2       <= instr[24:20];
      bus.out_rd        <= rd;
      bus.out_funct3    <= funct3;
      bus.out_imm       <= d_imm;
      bus.out_alu_op    <= d_alu;
      bus.out_rd_we     <= d_rd_we;
      bus.out_is_load   <= d_load;
      bus.out_is_store  <= d_store;
      bus.out_is_branch <= d_branch;
      bus.out_is_jal    <= d_jal;
      bus.out_is_jalr   <= d_jalr;
      bus.out_is_lui    <= d_lui;
      bus.out_is_auipc  <= d_auipc;
      bus.out_is_ecall  <= d_ecall;
      bus.out_is_ebreak <= d_ebreak;
      bus.out_illegal   <= d_ill;
      if (d_ill && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Randomised self-checking bench for riscv_decode_stage against a behavioural decode model.
module tb_riscv_decode_stage;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [15:0] illegal_cnt;
  logic [1:0]  cnt2;

  riscv_decode_stage_if #(.XLEN(32)) bus ();
  riscv_decode_stage_if #(.XLEN(32)) bus2 ();

  riscv_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave), .illegal_cnt(illegal_cnt));
  riscv_decode_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2.slave), .illegal_cnt(cnt2));

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.in_pc     = bus.in_pc;
  assign bus2.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        rd_we, ld, st, br, jal, jalr, lui, auipc, ecall, ebreak, illegal;
  } bundle_t;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  logic [4:0] base_alu [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

  // Decode directly from the ISA field definitions
  function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
    bundle_t b;
    logic signed [31:0] si;
    logic [31:0] s20, s25, s31;
    logic [2:0] f3;
    logic [6:0] f7;
    logic wr;
    b = '0; wr = 1'b0;
    si = $signed(i);
    s20 = si >>> 20; s25 = si >>> 25; s31 = si >>> 31;
    f3 = i[14:12]; f7 = i[31:25];
    b.pc = pc; b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7]; b.f3 = f3;
    case (i[6:0])
      7'h37: begin b.lui = 1; b.imm = i & 32'hFFFFF000; b.alu = 5'd10; wr = 1; end
      7'h17: begin b.auipc = 1; b.imm = i & 32'hFFFFF000; wr = 1; end
      7'h6F: begin
        b.jal = 1; wr = 1;
        b.imm = (s31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      7'h67: begin b.jalr = 1; b.imm = s20; wr = 1; b.illegal = (f3 != 0); end
      7'h63: begin
        b.br = 1;
        b.imm = (s31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        b.illegal = (f3 == 2) || (f3 == 3);
        b.alu = (f3 < 2) ? 5'd1 : (f3 < 6) ? 5'd3 : 5'd4;
      end
      7'h03: begin b.ld = 1; b.imm = s20; wr = 1; b.illegal = (f3 == 3) || (f3 == 6) || (f3 == 7); end
      7'h23: begin b.st = 1; b.imm = (s25 << 5) | 32'(i[11:7]); b.illegal = (f3 >= 3); end
      7'h13: begin
        b.imm = s20; wr = 1; b.alu = base_alu[f3];
        if (f3 == 1 && f7 != 0) b.illegal = 1;
        if (f3 == 5) begin
          if (f7 == 7'h20) b.alu = 5'd7;
          else if (f7 != 0) b.illegal = 1;
        end
      end
      7'h33: begin
        wr = 1;
        if (f7 == 0) b.alu = base_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) b.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 5) b.alu = 5'd7;
`ifdef RISCV_DECODE_RV32M_EN
        else if (f7 == 7'h01) b.alu = 5'(11 + f3);
`endif
        else b.illegal = 1;
      end
      7'h73: begin
        b.imm = s20;
        if (i == 32'h00000073) b.ecall = 1;
        else if (i == 32'h00100073) b.ebreak = 1;
        else b.illegal = 1;
      end
      default: b.illegal = 1;
    endcase
    if (b.illegal) begin
      {b.ld, b.st, b.br, b.jal, b.jalr, b.lui, b.auipc, b.ecall, b.ebreak} = '0;
      b.alu = 5'd0; wr = 0;
    end
    b.rd_we = wr && (b.rd != 0);
    return b;
  endfunction

  bundle_t exp_b = '0;
  logic exp_valid = 1'b0;
  logic exp_zero  = 1'b1;
  int   exp_cnt   = 0;
  int   exp_cnt2  = 0;

  // Reference pipeline register, advanced on the same edge as the DUT
  always @(posedge clk) begin
    if (rst) begin
      exp_valid = 0; exp_b = '0; exp_zero = 1; exp_cnt = 0; exp_cnt2 = 0;
    end else if (flush) begin
      exp_valid = 0;
    end else if (bus.in_valid && (!exp_valid || bus.out_ready)) begin
      exp_b = model(bus.in_instr, bus.in_pc);
      exp_valid = 1; exp_zero = 0;
      if (exp_b.illegal) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end else if (bus.out_ready) begin
      exp_valid = 0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    chk("in_ready", 32'(bus.in_ready), 32'(!exp_valid || bus.out_ready));
    chk("illegal_cnt", 32'(illegal_cnt), exp_cnt);
    chk("illegal_cnt_sat", 32'(cnt2), exp_cnt2);
    if (exp_valid || exp_zero) begin
      chk("out_pc", bus.out_pc, exp_b.pc);
      chk("out_regs", 32'({bus.out_rs1, bus.out_rs2, bus.out_rd}), 32'({exp_b.rs1, exp_b.rs2, exp_b.rd}));
      chk("out_funct3", 32'(bus.out_funct3), 32'(exp_b.f3));
      chk("out_imm", bus.out_imm, exp_b.imm);
      chk("out_alu_op", 32'(bus.out_alu_op), 32'(exp_b.alu));
      chk("out_rd_we", 32'(bus.out_rd_we), 32'(exp_b.rd_we));
      chk("out_flags", 32'({bus.out_is_load, bus.out_is_store, bus.out_is_branch, bus.out_is_jal,
                            bus.out_is_jalr, bus.out_is_lui, bus.out_is_auipc, bus.out_is_ecall,
                            bus.out_is_ebreak}),
          32'({exp_b.ld, exp_b.st, exp_b.br, exp_b.jal, exp_b.jalr, exp_b.lui, exp_b.auipc,
               exp_b.ecall, exp_b.ebreak}));
      chk("out_illegal", 32'(bus.out_illegal), 32'(exp_b.illegal));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    rst = r; bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) i[6:0] = ops[k];
    if (k == 7 || k == 8) i[31:25] = f7s[$urandom_range(0, 3)];
    if (k == 9) begin
      case ($urandom_range(0, 2))
        0: i = 32'h00000073;
        1: i = 32'h00100073;
        default: ;
      endcase
    end
    return i;
  endfunction

  bundle_t pin;

  initial begin
    drive(1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
    pin = model(32'hFFF00293, 32'h100);
    chk("model_addi_imm", pin.imm, 32'hFFFFFFFF);
    pin = model(32'hFE208CE3, 32'h0);
    chk("model_beq_imm", pin.imm, 32'hFFFFFFF8);
    repeat (2) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'h0);
    chk("rst_out_imm", bus.out_imm, 32'h0);

    drive(0, 1, 32'hFFF00293, 32'h100, 1, 0); tick();
    chk("addi_valid", 32'(bus.out_valid), 32'h1);
    chk("addi_rd", 32'(bus.out_rd), 32'd5);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_rd_we", 32'(bus.out_rd_we), 32'h1);
    chk("addi_pc", bus.out_pc, 32'h100);

    drive(0, 1, 32'h402081B3, 32'h104, 1, 0); tick();
    chk("sub_alu", 32'(bus.out_alu_op), 32'd1);
    chk("sub_rd_we", 32'(bus.out_rd_we), 32'h1);
    drive(0, 1, 32'hFE208CE3, 32'h108, 1, 0); tick();
    chk("beq_valid", 32'(bus.out_valid), 32'h1);
    chk("beq_branch", 32'(bus.out_is_branch), 32'h1);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFF8);
    chk("beq_rd_we", 32'(bus.out_rd_we), 32'h0);

    drive(0, 1, 32'h00100093, 32'h200, 1, 0); tick();
    drive(0, 1, 32'h00200113, 32'h204, 0, 0);
    repeat (3) begin
      tick();
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_hold_pc", bus.out_pc, 32'h200);
    end
    drive(0, 1, 32'h00200113, 32'h204, 1, 0); tick();
    chk("bp_release_pc", bus.out_pc, 32'h204);
    drive(0, 0, 32'h0, 32'h0, 1, 0); tick();
    chk("bp_no_dup", 32'(bus.out_valid), 32'h0);

    drive(0, 1, 32'h00000000, 32'h300, 1, 0); tick();
    drive(0, 1, 32'h00003003, 32'h304, 1, 0); tick();
    chk("ill_cnt2", 32'(illegal_cnt), 32'd2);
    chk("ill_flag", 32'(bus.out_illegal), 32'h1);
    chk("ill_rd_we", 32'(bus.out_rd_we), 32'h0);
    repeat (3) begin drive(0, 1, 32'h0, 32'h308, 1, 0); tick(); end
    chk("ill_cnt5", 32'(illegal_cnt), 32'd5);
    chk("ill_sat", 32'(cnt2), 32'd3);

    drive(0, 1, 32'h0, 32'h400, 1, 1); tick();
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    chk("flush_cnt", 32'(illegal_cnt), 32'd5);

    drive(0, 1, 32'h022081B3, 32'h500, 1, 0); tick();
`ifdef RISCV_DECODE_RV32M_EN
    chk("mul_alu", 32'(bus.out_alu_op), 32'd11);
    chk("mul_rd_we", 32'(bus.out_rd_we), 32'h1);
`else
    chk("mul_illegal", 32'(bus.out_illegal), 32'h1);
`endif

    drive(0, 1, 32'hFFF00293, 32'h600, 1, 0); tick();
    drive(1, 1, 32'h402081B3, 32'h604, 1, 0); tick();
    chk("rst_mid_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_mid_pc", bus.out_pc, 32'h0);
    chk("rst_mid_rd", 32'(bus.out_rd), 32'h0);
    chk("rst_mid_cnt", 32'(illegal_cnt), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
            $urandom & 32'hFFFFFFFC, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      tick();
    end
    drive(0, 0, 32'h0, 32'h0, 1, 0);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
